lif_timestep_scheduler: RTL and testbench

Time-multiplexes one shared LIF update datapath across N_NEURONS virtual neurons.
- Each neuron's membrane potential and refractory counter live in an internal state file.
- On each timestep pulse, the block walks neuron indices 0..N-1. For each neuron it fetches the synaptic input vector (req/ack), issues an update to the LIF datapath, and writes back the result.
- Output spikes are forwarded to the spike router over a valid/ready stream.
- Sits between the network timestep generator, the weight/spike memory, the LIF datapath and the spike router.

---
 rtl/snn_pkg.sv | 34 +++
 rtl/lif_timestep_scheduler_if.sv | 37 +++
 rtl/neuron_state_ram.sv | 33 +++
 rtl/lif_timestep_scheduler.sv | 170 +++++++++++++++++
 tb/tb_lif_timestep_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and widths for the LIF timestep scheduler: FSM states,
// datapath widths, the per-neuron state record and its refractory update.
package snn_pkg;

    localparam int IDX_W  = 4;
    localparam int V_W    = 8;
    localparam int TREF_W = 4;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_FETCH = 4'd2,
        S_ISSUE = 4'd3,
        S_WAIT  = 4'd4,
        S_WB    = 4'd5,
        S_EMIT  = 4'd6,
        S_NEXT  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    typedef struct packed {
        logic [V_W-1:0]    v;
        logic [TREF_W-1:0] tr;
    } neuron_t;

    // A refractory neuron is held at rest while its counter runs down.
    function automatic neuron_t refractory_tick(input neuron_t e);
        neuron_t r;
        r.v  = {V_W{1'b0}};
        r.tr = e.tr - TREF_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/lif_timestep_scheduler_if.sv
// Bundle of the scheduler's handshakes: timestep control, synaptic fetch,
// LIF datapath issue/result and the spike router stream.
interface lif_timestep_scheduler_if;

    logic                       ts_start;
    logic                       busy;
    logic                       ts_done;
    logic [snn_pkg::IDX_W:0]    spike_count;

    logic                       wt_req;
    logic [snn_pkg::IDX_W-1:0]  wt_idx;
    logic                       wt_ack;

    logic                       lif_valid;
    logic [snn_pkg::V_W-1:0]    lif_v_in;
    logic                       lif_done;
    logic [snn_pkg::V_W-1:0]    lif_v_out;
    logic [snn_pkg::TREF_W-1:0] lif_tr_out;
    logic                       lif_spike;

    logic                       spk_valid;
    logic [snn_pkg::IDX_W-1:0]  spk_idx;
    logic                       spk_ready;

    modport master (
        input  ts_start, wt_ack, lif_done, lif_v_out, lif_tr_out, lif_spike, spk_ready,
        output busy, ts_done, spike_count, wt_req, wt_idx, lif_valid, lif_v_in,
               spk_valid, spk_idx
    );

    modport slave (
        output ts_start, wt_ack, lif_done, lif_v_out, lif_tr_out, lif_spike, spk_ready,
        input  busy, ts_done, spike_count, wt_req, wt_idx, lif_valid, lif_v_in,
               spk_valid, spk_idx
    );

endinterface

// File: rtl/neuron_state_ram.sv
// Per-neuron {v, tr} register file: combinational read, one synchronous
// write port, whole array cleared while reset_n is low.
module neuron_state_ram
    import snn_pkg::*;
#(
    parameter int N_NEURONS = 16
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output neuron_t          o_rd_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  neuron_t          i_wr_data
);

    neuron_t r_mem [N_NEURONS];

    // Clear every entry on reset, otherwise update the addressed entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (!reset_n) begin
                r_mem[i] <= {(V_W+TREF_W){1'b0}};
            end else if (i_we && (i_wr_idx == IDX_W'(i))) begin
                r_mem[i] <= i_wr_data;
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/lif_timestep_scheduler.sv
// Walks all virtual neurons once per timestep through a single shared LIF
// datapath, skipping refractory neurons and forwarding spikes to the router.
module lif_timestep_scheduler
    import snn_pkg::*;
#(
    parameter int N_NEURONS = 16
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    lif_timestep_scheduler_if.master bus
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [V_W-1:0]    r_v_res;
    logic [TREF_W-1:0] r_tr_res;
    logic              r_spike;

    logic              r_busy;
    logic              r_ts_done;
    logic [IDX_W:0]    r_spike_count;
    logic              r_wt_req;
    logic [IDX_W-1:0]  r_wt_idx;
    logic              r_lif_valid;
    logic [V_W-1:0]    r_lif_v_in;
    logic              r_spk_valid;
    logic [IDX_W-1:0]  r_spk_idx;

    neuron_t           w_rd;
    neuron_t           w_wr_data;
    logic              w_we;

    neuron_state_ram #(.N_NEURONS(N_NEURONS)) u_state (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd),
        .i_we      (w_we),
        .i_wr_idx  (r_idx),
        .i_wr_data (w_wr_data)
    );

    // State-file write: refractory countdown in LOAD, datapath result in WB
    always_comb begin
        w_we      = 1'b0;
        w_wr_data = w_rd;
        if ((r_state == S_LOAD) && (w_rd.tr != {TREF_W{1'b0}})) begin
            w_we      = 1'b1;
            w_wr_data = refractory_tick(w_rd);
        end else if (r_state == S_WB) begin
            w_we         = 1'b1;
            w_wr_data.v  = r_v_res;
            w_wr_data.tr = r_tr_res;
        end else begin
            w_we      = 1'b0;
            w_wr_data = w_rd;
        end
    end

    // Sweep controller with all handshake outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= {IDX_W{1'b0}};
            r_v_res       <= {V_W{1'b0}};
            r_tr_res      <= {TREF_W{1'b0}};
            r_spike       <= 1'b0;
            r_busy        <= 1'b0;
            r_ts_done     <= 1'b0;
            r_spike_count <= {(IDX_W+1){1'b0}};
            r_wt_req      <= 1'b0;
            r_wt_idx      <= {IDX_W{1'b0}};
            r_lif_valid   <= 1'b0;
            r_lif_v_in    <= {V_W{1'b0}};
            r_spk_valid   <= 1'b0;
            r_spk_idx     <= {IDX_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ts_start) begin
                        r_state       <= S_LOAD;
                        r_idx         <= {IDX_W{1'b0}};
                        r_spike_count <= {(IDX_W+1){1'b0}};
                        r_busy        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_rd.tr != {TREF_W{1'b0}}) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_state  <= S_FETCH;
                        r_wt_req <= 1'b1;
                        r_wt_idx <= r_idx;
                    end
                end
                S_FETCH: begin
                    if (bus.wt_ack) begin
                        r_wt_req    <= 1'b0;
                        r_lif_valid <= 1'b1;
                        r_lif_v_in  <= w_rd.v;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_lif_valid <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // Result is a single-cycle pulse, so capture it here for WB
                    if (bus.lif_done) begin
                        r_v_res  <= bus.lif_v_out;
                        r_tr_res <= bus.lif_tr_out;
                        r_spike  <= bus.lif_spike;
                        r_state  <= S_WB;
                    end
                end
                S_WB: begin
                    if (r_spike) begin
                        r_spk_valid   <= 1'b1;
                        r_spk_idx     <= r_idx;
                        r_spike_count <= r_spike_count + (IDX_W+1)'(1);
                        r_state       <= S_EMIT;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_EMIT: begin
                    if (bus.spk_ready) begin
                        r_spk_valid <= 1'b0;
                        r_state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_idx == IDX_W'(N_NEURONS - 1)) begin
                        r_state   <= S_DONE;
                        r_ts_done <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_ts_done <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_ts_done   <= 1'b0;
                    r_wt_req    <= 1'b0;
                    r_lif_valid <= 1'b0;
                    r_spk_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.ts_done     = r_ts_done;
    assign bus.spike_count = r_spike_count;
    assign bus.wt_req      = r_wt_req;
    assign bus.wt_idx      = r_wt_idx;
    assign bus.lif_valid   = r_lif_valid;
    assign bus.lif_v_in    = r_lif_v_in;
    assign bus.spk_valid   = r_spk_valid;
    assign bus.spk_idx     = r_spk_idx;

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Scoreboard bench: a per-sweep neuron model queues the expected issue/spike/done
// events, responders emulate memory, datapath and router, a monitor checks.
module tb_lif_timestep_scheduler;
    import snn_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    lif_timestep_scheduler_if bus();

    lif_timestep_scheduler #(.N_NEURONS(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int kind;   // 0 = datapath issue, 1 = spike accepted, 2 = sweep done
        int idx;
        int val;
    } exp_t;
    exp_t sbq[$];

    int m_v[N];
    int m_tr[N];

    int p_v[N];
    int p_tr[N];
    bit p_spk[N];
    int p_ack[N];
    int p_done[N];
    int p_stall[N];

    bit spur_arm = 1'b0;
    int spk_valid_cycles = 0;
    int fetch0_cycles = 0;
    int ts_done_seen = 0;
    int first_cnt = 0;
    int first_busy = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_evt(input int kind, input int idx, input int val, input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected event idx=%0d val=%0d, none expected", nm, idx, val);
        end else begin
            e = sbq.pop_front();
            check({nm, "_kind"}, kind, e.kind);
            check({nm, "_idx"}, idx, e.idx);
            check({nm, "_val"}, val, e.val);
        end
    endtask

    // Reference: what one whole sweep should do, given the planned responses
    function automatic void model_sweep();
        int cnt = 0;
        for (int n = 0; n < N; n++) begin
            if (m_tr[n] != 0) begin
                m_tr[n] = m_tr[n] - 1;
                m_v[n]  = 0;
            end else begin
                sbq.push_back('{0, n, m_v[n]});
                m_v[n]  = p_v[n] % 256;
                m_tr[n] = p_spk[n] ? p_tr[n] : 0;
                if (p_spk[n]) begin
                    sbq.push_back('{1, n, 0});
                    cnt++;
                end
            end
        end
        sbq.push_back('{2, 0, cnt});
    endfunction

    function automatic void model_clear();
        for (int n = 0; n < N; n++) begin
            m_v[n]  = 0;
            m_tr[n] = 0;
        end
    endfunction

    function automatic void set_defaults(input int voff);
        for (int n = 0; n < N; n++) begin
            p_v[n]     = n + voff;
            p_tr[n]    = 0;
            p_spk[n]   = 1'b0;
            p_ack[n]   = 0;
            p_done[n]  = 0;
            p_stall[n] = 0;
        end
    endfunction

    // Synaptic memory: ack after p_ack[idx] extra cycles of wt_req
    initial begin
        int cnt = 0;
        bus.wt_ack = 1'b0;
        forever begin
            @(negedge clk); #1;
            bus.wt_ack = 1'b0;
            if (reset_n === 1'b1 && bus.wt_req === 1'b1) begin
                if (cnt >= p_ack[bus.wt_idx]) begin
                    bus.wt_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // LIF datapath: result p_done[idx] cycles after the WAIT entry, garbage otherwise
    initial begin
        bit pend = 1'b0;
        int cnt = 0;
        int pidx = 0;
        bus.lif_done = 1'b0; bus.lif_v_out = '0; bus.lif_tr_out = '0; bus.lif_spike = 1'b0;
        forever begin
            @(negedge clk); #1;
            bus.lif_done   = 1'b0;
            bus.lif_v_out  = V_W'($urandom);
            bus.lif_tr_out = TREF_W'($urandom);
            bus.lif_spike  = 1'($urandom_range(0, 1));
            if (reset_n !== 1'b1) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    bus.lif_done   = 1'b1;
                    bus.lif_v_out  = V_W'(p_v[pidx]);
                    bus.lif_tr_out = TREF_W'(p_spk[pidx] ? p_tr[pidx] : 0);
                    bus.lif_spike  = p_spk[pidx];
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (spur_arm && bus.wt_req === 1'b1) begin
                bus.lif_done   = 1'b1;
                bus.lif_v_out  = V_W'(8'hEE);
                bus.lif_tr_out = TREF_W'(4'h5);
                bus.lif_spike  = 1'b1;
                spur_arm = 1'b0;
            end
            if (reset_n === 1'b1 && bus.lif_valid === 1'b1) begin
                pend = 1'b1;
                cnt  = p_done[bus.wt_idx];
                pidx = bus.wt_idx;
            end
        end
    end

    // Spike router: hold ready low for p_stall[idx] cycles of each event
    initial begin
        int cnt = 0;
        bus.spk_ready = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (bus.spk_valid === 1'b1) begin
                if (cnt >= p_stall[bus.spk_idx]) begin
                    bus.spk_ready = 1'b1;
                end else begin
                    bus.spk_ready = 1'b0;
                    cnt++;
                end
            end else begin
                bus.spk_ready = 1'($urandom_range(0, 1));
                cnt = 0;
            end
        end
    end

    // Monitor: protocol checks plus scoreboard pops on every observed event
    initial begin
        bit pv_req = 1'b0, pv_ack = 1'b0, pv_lv = 1'b0, pv_spk = 1'b0, pv_rdy = 1'b0;
        int p_widx = 0, p_sidx = 0;
        forever begin
            @(negedge clk); #2;
            if (reset_n !== 1'b1) begin
                pv_req = 1'b0; pv_ack = 1'b0; pv_lv = 1'b0; pv_spk = 1'b0; pv_rdy = 1'b0;
            end else begin
                if (pv_req && !pv_ack) begin
                    check("wt_req_held", int'(bus.wt_req), 1);
                    check("wt_idx_stable", int'(bus.wt_idx), p_widx);
                end
                if (pv_req && pv_ack) check("lif_valid_after_ack", int'(bus.lif_valid), 1);
                if (pv_lv) check("lif_valid_single", int'(bus.lif_valid), 0);
                if (pv_spk && !pv_rdy) begin
                    check("spk_valid_held", int'(bus.spk_valid), 1);
                    check("spk_idx_stable", int'(bus.spk_idx), p_sidx);
                end
                if (bus.wt_req === 1'b1 && bus.wt_idx == 0) fetch0_cycles++;
                if (bus.spk_valid === 1'b1) spk_valid_cycles++;
                if (bus.lif_valid === 1'b1)
                    expect_evt(0, int'(bus.wt_idx), int'(bus.lif_v_in), "lif_issue");
                if (bus.spk_valid === 1'b1 && bus.spk_ready === 1'b1)
                    expect_evt(1, int'(bus.spk_idx), 0, "spike");
                if (bus.ts_done === 1'b1) begin
                    ts_done_seen++;
                    expect_evt(2, 0, int'(bus.spike_count), "sweep_done");
                    check("busy_low_at_done", int'(bus.busy), 0);
                end
                pv_req = bus.wt_req;  pv_ack = bus.wt_ack;  p_widx = bus.wt_idx;
                pv_lv  = bus.lif_valid;
                pv_spk = bus.spk_valid; pv_rdy = bus.spk_ready; p_sidx = bus.spk_idx;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        int'(bus.busy), 0);
        check({tag, "_ts_done"},     int'(bus.ts_done), 0);
        check({tag, "_wt_req"},      int'(bus.wt_req), 0);
        check({tag, "_lif_valid"},   int'(bus.lif_valid), 0);
        check({tag, "_spk_valid"},   int'(bus.spk_valid), 0);
        check({tag, "_wt_idx"},      int'(bus.wt_idx), 0);
        check({tag, "_spk_idx"},     int'(bus.spk_idx), 0);
        check({tag, "_lif_v_in"},    int'(bus.lif_v_in), 0);
        check({tag, "_spike_count"}, int'(bus.spike_count), 0);
    endtask

    // One full sweep; cyc counts from the ts_start cycle through the ts_done cycle
    task automatic run_sweep(input bit poke, output int cyc);
        bit done = 1'b0;
        model_sweep();
        spk_valid_cycles = 0;
        fetch0_cycles = 0;
        @(negedge clk); #1;
        bus.ts_start = 1'b1;
        cyc = 1;
        while (!done && cyc < 4000) begin
            @(negedge clk); #1;
            bus.ts_start = poke ? (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0) : 1'b0;
            #2;
            cyc++;
            if (cyc == 2) begin
                first_cnt  = int'(bus.spike_count);
                first_busy = int'(bus.busy);
            end
            if (bus.ts_done === 1'b1) done = 1'b1;
        end
        bus.ts_start = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL sweep_timeout: no ts_done after %0d cycles, expected one", cyc);
            sbq.delete();
        end
        check("scoreboard_drained", sbq.size(), 0);
    endtask

    initial begin
        int cyc;
        int seen0;
        bit found;

        reset_n = 1'b0;
        bus.ts_start = 1'b0;
        set_defaults(10);
        model_clear();
        repeat (3) @(negedge clk);
        #3;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Baseline sweep: immediate ack, one-cycle datapath, no spikes
        run_sweep(1'b0, cyc);
        check("latency_16x6p2", cyc, N * 6 + 2);

        // Second sweep sees the written-back potentials idx+10
        set_defaults(20);
        run_sweep(1'b0, cyc);
        check("latency_repeat", cyc, N * 6 + 2);

        // Neuron 3 spikes with tref=2 while the router stalls 4 cycles
        p_spk[3] = 1'b1; p_tr[3] = 2; p_stall[3] = 4; p_v[3] = 99;
        run_sweep(1'b0, cyc);
        check("spk_valid_cycles", spk_valid_cycles, 5);
        check("latency_spike_stall", cyc, N * 6 + 2 + 5);
        p_spk[3] = 1'b0; p_stall[3] = 0;
        run_sweep(1'b0, cyc);
        check("latency_refractory1", cyc, N * 6 + 2 - 4);
        run_sweep(1'b0, cyc);
        check("latency_refractory2", cyc, N * 6 + 2 - 4);
        run_sweep(1'b0, cyc);
        check("latency_recovered", cyc, N * 6 + 2);

        // Neurons 0, 7, 15 spike: count held after done, cleared on next start
        p_spk[0] = 1'b1; p_spk[7] = 1'b1; p_spk[15] = 1'b1;
        run_sweep(1'b0, cyc);
        repeat (3) @(negedge clk);
        #3;
        check("spike_count_held", int'(bus.spike_count), 3);
        check("idle_after_done", int'(bus.busy), 0);
        set_defaults(30);
        run_sweep(1'b0, cyc);
        check("spike_count_cleared", first_cnt, 0);
        check("busy_after_start", first_busy, 1);

        // ts_start pokes while busy and a stray lif_done during FETCH
        seen0 = ts_done_seen;
        spur_arm = 1'b1;
        p_ack[0] = 2;
        run_sweep(1'b1, cyc);
        repeat (20) @(negedge clk);
        #3;
        check("single_ts_done", ts_done_seen - seen0, 1);
        check("stray_done_injected", int'(spur_arm), 0);
        check("idle_after_pokes", int'(bus.busy), 0);

        // wt_ack held off 7 cycles on neuron 0
        set_defaults(40);
        p_ack[0] = 7;
        run_sweep(1'b0, cyc);
        check("fetch0_req_cycles", fetch0_cycles, 8);
        check("latency_ack_delay", cyc, N * 6 + 2 + 7);

        // Reset while neuron 5 sits in WAIT
        set_defaults(50);
        p_done[5] = 30;
        model_sweep();
        @(negedge clk); #1;
        bus.ts_start = 1'b1;
        @(negedge clk); #1;
        bus.ts_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk); #3;
            if (bus.lif_valid === 1'b1 && bus.wt_idx == 5) found = 1'b1;
        end
        check("reached_neuron5", int'(found), 1);
        @(negedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk); #3;
        check_all_zero("midreset");
        reset_n = 1'b1;
        sbq.delete();
        model_clear();
        repeat (40) @(negedge clk);
        #3;
        check("no_done_after_reset", int'(bus.busy) + int'(bus.ts_done), 0);
        set_defaults(60);
        run_sweep(1'b0, cyc);
        check("latency_after_reset", cyc, N * 6 + 2);

        // Randomized sweeps: random potentials, spikes, tref and handshake delays
        for (int s = 0; s < 8; s++) begin
            for (int n = 0; n < N; n++) begin
                p_v[n]     = $urandom_range(0, 255);
                p_spk[n]   = ($urandom_range(0, 3) == 0);
                p_tr[n]    = $urandom_range(0, 3);
                p_ack[n]   = $urandom_range(0, 3);
                p_done[n]  = $urandom_range(0, 3);
                p_stall[n] = $urandom_range(0, 3);
            end
            run_sweep(1'($urandom_range(0, 1)), cyc);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
